// File: rtl/x4xx_qsfp_traffic_checker_if.sv
// AXI-Stream lane carrying one QSFP user data stream into the traffic checker.
interface x4xx_qsfp_traffic_checker_if #(
    parameter int unsigned DATA_W = 64
);
    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (
        output tdata,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/x4xx_qsfp_traffic_checker.sv
// Receive-side traffic checker for one QSFP lane.
// Checks a deterministic payload ({pkt_cnt, word_idx} in every 32-bit lane), packet length and
// packet count, and reports done/pass/timeout so a self-test can poll one status per lane.
module x4xx_qsfp_traffic_checker #(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned NUM_PKTS    = 16,
    parameter int unsigned PKT_LEN     = 8,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    x4xx_qsfp_traffic_checker_if.slave        s_axis,
    output logic                              done,
    output logic                              pass,
    output logic                              timeout,
    output logic [15:0]                       err_cnt,
    output logic [15:0]                       pkt_cnt
);

    localparam int unsigned LANES = DATA_W / 32;
    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [15:0]     LAST_IDX  = 16'(PKT_LEN - 1);
    localparam logic [15:0]     FINAL_PKT = 16'(NUM_PKTS - 1);
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush,
        StDone
    } state_e;

    state_e          state;
    logic            tready_q;
    logic [15:0]     word_idx;
    logic [WD_W-1:0] wd_cnt;
    // Error from the beat accepted last cycle, retired into err_cnt this cycle.
    logic            err_pend;
    // Set once the missing-tlast error has been charged to the current packet.
    logic            overrun_flagged;

    logic            accept;
    logic [31:0]     expected_word;
    logic            data_err;
    logic            at_last_idx;
    logic            len_err;
    logic            beat_err;

    assign s_axis.tready = tready_q;
    assign accept        = s_axis.tvalid & tready_q;

    // Classify the beat on the bus: payload mismatch and length violation.
    always_comb begin
        expected_word = {pkt_cnt, word_idx};
        data_err      = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (s_axis.tdata[32*i +: 32] != expected_word) begin
                data_err = 1'b1;
            end
        end
        at_last_idx = (word_idx == LAST_IDX);
        if (s_axis.tlast) begin
            len_err = !at_last_idx;
        end else begin
            len_err = at_last_idx && !overrun_flagged;
        end
        // A beat contributes at most one error even if both checks fire.
        beat_err = data_err | len_err;
    end

    // Run-control FSM with the beat counters, watchdog and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= StIdle;
            tready_q        <= 1'b0;
            word_idx        <= '0;
            wd_cnt          <= '0;
            err_pend        <= 1'b0;
            overrun_flagged <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            timeout         <= 1'b0;
            err_cnt         <= '0;
            pkt_cnt         <= '0;
        end else begin
            // Compare stage retires one cycle after the beat; saturate rather than wrap.
            err_pend <= 1'b0;
            if (err_pend && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end

            case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state           <= StRun;
                        tready_q        <= 1'b1;
                        word_idx        <= '0;
                        wd_cnt          <= '0;
                        err_pend        <= 1'b0;
                        overrun_flagged <= 1'b0;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        timeout         <= 1'b0;
                        err_cnt         <= '0;
                        pkt_cnt         <= '0;
                    end
                end

                StRun: begin
                    if (accept) begin
                        // An accepted beat always wins over the watchdog's terminal cycle.
                        err_pend <= beat_err;
                        wd_cnt   <= '0;
                        if (s_axis.tlast) begin
                            pkt_cnt         <= pkt_cnt + 16'd1;
                            word_idx        <= '0;
                            overrun_flagged <= 1'b0;
                            if (pkt_cnt == FINAL_PKT) begin
                                state    <= StFlush;
                                tready_q <= 1'b0;
                            end
                        end else begin
                            word_idx <= word_idx + 16'd1;
                            if (at_last_idx) begin
                                overrun_flagged <= 1'b1;
                            end
                        end
                    end else if (wd_cnt == WD_LAST) begin
                        timeout  <= 1'b1;
                        state    <= StFlush;
                        tready_q <= 1'b0;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end

                StFlush: begin
                    // err_cnt is still absorbing err_pend this cycle, so include it directly.
                    state <= StDone;
                    done  <= 1'b1;
                    pass  <= !timeout && (err_cnt == 16'd0) && !err_pend;
                end

                default: begin
                    state    <= StIdle;
                    tready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_x4xx_qsfp_traffic_checker.sv
// Self-checking bench for x4xx_qsfp_traffic_checker: scenario table, hand-written corner cases
// and randomized runs scored against a packet-level reference model.
module tb_x4xx_qsfp_traffic_checker;

    localparam int unsigned DATA_W      = 64;
    localparam int unsigned NUM_PKTS    = 4;
    localparam int unsigned PKT_LEN     = 8;
    localparam int unsigned TIMEOUT_CYC = 1000;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [15:0] err_cnt;
    logic [15:0] pkt_cnt;

    x4xx_qsfp_traffic_checker_if #(.DATA_W(DATA_W)) axis ();

    x4xx_qsfp_traffic_checker #(
        .DATA_W      (DATA_W),
        .NUM_PKTS    (NUM_PKTS),
        .PKT_LEN     (PKT_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .s_axis  (axis),
        .done    (done),
        .pass    (pass),
        .timeout (timeout),
        .err_cnt (err_cnt),
        .pkt_cnt (pkt_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        int          bad_pkt;
        int          bad_word;
        logic [63:0] bad_data;
        int          len_pkt;
        int          len_val;
        int unsigned exp_err;
        bit          exp_pass;
    } vec_t;

    vec_t vecs [6];

    // Per-run packet plan: beats per packet, corruption mask per beat, idle cycles before a beat.
    int unsigned plan_len [NUM_PKTS];
    logic [63:0] plan_xor [NUM_PKTS][16];
    int unsigned plan_gap [NUM_PKTS][16];

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic summary_and_finish();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    function automatic logic [63:0] good_word(input int p, input int w);
        logic [15:0] p16;
        logic [15:0] w16;
        p16 = 16'(p);
        w16 = 16'(w);
        return {p16, w16, p16, w16};
    endfunction

    task automatic set_vec(input int i, input string n, input int bp, input int bw,
                           input logic [63:0] bd, input int lp, input int lv,
                           input int unsigned ee, input bit ep);
        vecs[i].name     = n;
        vecs[i].bad_pkt  = bp;
        vecs[i].bad_word = bw;
        vecs[i].bad_data = bd;
        vecs[i].len_pkt  = lp;
        vecs[i].len_val  = lv;
        vecs[i].exp_err  = ee;
        vecs[i].exp_pass = ep;
    endtask

    task automatic clear_plan();
        for (int p = 0; p < int'(NUM_PKTS); p++) begin
            plan_len[p] = PKT_LEN;
            for (int w = 0; w < 16; w++) begin
                plan_xor[p][w] = '0;
                plan_gap[p][w] = 0;
            end
        end
    endtask

    // Present one beat after `gap` idle cycles; returns at posedge+1 after it was accepted.
    task automatic send_beat(input logic [63:0] data, input bit last, input int unsigned gap);
        bit acc;
        axis.tvalid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        axis.tdata  = data;
        axis.tlast  = last;
        axis.tvalid = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 1100 && !acc; n++) begin
            @(negedge clk);
            acc = axis.tready;
            @(posedge clk);
            #1;
        end
        axis.tvalid = 1'b0;
        axis.tlast  = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL beat_accept: tready stayed 0, required 1");
            summary_and_finish();
        end
    endtask

    task automatic send_clean_packet(input int p);
        for (int w = 0; w < int'(PKT_LEN); w++) begin
            send_beat(good_word(p, w), w == int'(PKT_LEN) - 1, 0);
        end
    endtask

    // Pulse start and confirm the run begins with cleared status.
    task automatic do_start(input string name);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check({name, "_start_done"}, done, 0);
        check({name, "_start_pass"}, pass, 0);
        check({name, "_start_timeout"}, timeout, 0);
        check({name, "_start_err"}, err_cnt, 0);
        check({name, "_start_pkt"}, pkt_cnt, 0);
        check({name, "_start_tready"}, axis.tready, 1);
        @(posedge clk);
        #1;
    endtask

    // Drive the whole plan and derive the expected error count from the packet rules.
    task automatic drive_plan(input string name, input int start_pkt, output int unsigned exp_err);
        exp_err = 0;
        for (int p = 0; p < int'(NUM_PKTS); p++) begin
            for (int w = 0; w < int'(plan_len[p]); w++) begin
                bit last;
                bit data_bad;
                bit len_bad;
                last     = (w == int'(plan_len[p]) - 1);
                data_bad = (plan_xor[p][w] != 64'd0);
                len_bad  = last ? (w != int'(PKT_LEN) - 1) : (w == int'(PKT_LEN) - 1);
                if (data_bad || len_bad) exp_err++;
                if (p == start_pkt && w == 0) begin
                    start = 1'b1;
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                    @(negedge clk);
                    check({name, "_start_in_run_pkt"}, pkt_cnt, p);
                    check({name, "_start_in_run_tready"}, axis.tready, 1);
                    check({name, "_start_in_run_done"}, done, 0);
                    @(posedge clk);
                    #1;
                end
                send_beat(good_word(p, w) ^ plan_xor[p][w], last, plan_gap[p][w]);
            end
        end
    endtask

    // Called right after the final beat: done must rise exactly two clocks later.
    task automatic finish_checks(input string name, input int unsigned exp_err, input bit exp_pass);
        @(negedge clk);
        check({name, "_done_early"}, done, 0);
        check({name, "_tready_drop"}, axis.tready, 0);
        @(negedge clk);
        check({name, "_done"}, done, 1);
        check({name, "_pass"}, pass, exp_pass);
        check({name, "_err_cnt"}, err_cnt, exp_err);
        check({name, "_pkt_cnt"}, pkt_cnt, NUM_PKTS);
        check({name, "_timeout"}, timeout, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned exp_err;
        int          n;

        axis.tvalid = 1'b0;
        axis.tlast  = 1'b0;
        axis.tdata  = '0;

        set_vec(0, "clean",        -1, 0, 64'h0,                    -1, 8,  0, 1'b1);
        set_vec(1, "data_err",      1, 3, 64'h0001_0003_0001_0013, -1, 8,  1, 1'b0);
        set_vec(2, "early_tlast",  -1, 0, 64'h0,                     0, 6,  1, 1'b0);
        set_vec(3, "final_beat",    3, 7, 64'h0003_0007_0003_0107, -1, 8,  1, 1'b0);
        set_vec(4, "long_pkt",     -1, 0, 64'h0,                     2, 10, 2, 1'b0);
        set_vec(5, "data_and_len",  0, 5, 64'hDEAD_BEEF_0000_0005,   0, 6,  1, 1'b0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tready", axis.tready, 0);
        check("reset_done", done, 0);
        check("reset_pass", pass, 0);
        check("reset_timeout", timeout, 0);
        check("reset_err_cnt", err_cnt, 0);
        check("reset_pkt_cnt", pkt_cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        // Scenario table
        for (int i = 0; i < 6; i++) begin
            clear_plan();
            if (vecs[i].len_pkt >= 0) plan_len[vecs[i].len_pkt] = vecs[i].len_val;
            if (vecs[i].bad_pkt >= 0) begin
                plan_xor[vecs[i].bad_pkt][vecs[i].bad_word] =
                    vecs[i].bad_data ^ good_word(vecs[i].bad_pkt, vecs[i].bad_word);
            end
            do_start(vecs[i].name);
            drive_plan(vecs[i].name, -1, exp_err);
            finish_checks(vecs[i].name, vecs[i].exp_err, vecs[i].exp_pass);
        end

        // Watchdog abort after two packets
        do_start("timeout");
        send_clean_packet(0);
        send_clean_packet(1);
        n = 0;
        while (!done && n < 1100) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency", n, TIMEOUT_CYC + 2);
        check("timeout_flag", timeout, 1);
        check("timeout_pass", pass, 0);
        check("timeout_pkt_cnt", pkt_cnt, 2);
        check("timeout_err_cnt", err_cnt, 0);
        check("timeout_tready", axis.tready, 0);
        repeat (20) @(negedge clk);
        check("timeout_hold_done", done, 1);
        check("timeout_hold_flag", timeout, 1);
        @(posedge clk);
        #1;

        // Beat on the watchdog's terminal cycle wins
        clear_plan();
        plan_gap[1][0] = TIMEOUT_CYC - 1;
        do_start("wd_terminal");
        drive_plan("wd_terminal", -1, exp_err);
        finish_checks("wd_terminal", 0, 1'b1);

        // Asynchronous reset in the middle of packet 2
        do_start("mid_reset");
        send_clean_packet(0);
        send_clean_packet(1);
        for (int w = 0; w < 3; w++) send_beat(good_word(2, w), 1'b0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_tready", axis.tready, 0);
        check("mid_reset_pkt_cnt", pkt_cnt, 0);
        check("mid_reset_err_cnt", err_cnt, 0);
        check("mid_reset_done", done | pass | timeout, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_idle_done", done, 0);
        check("post_reset_idle_tready", axis.tready, 0);
        @(posedge clk);
        #1;
        clear_plan();
        do_start("after_reset");
        drive_plan("after_reset", -1, exp_err);
        finish_checks("after_reset", exp_err, 1'b1);

        // Randomized runs against the packet-level model
        for (int r = 0; r < 6; r++) begin
            int sp;
            clear_plan();
            for (int p = 0; p < int'(NUM_PKTS); p++) begin
                if (r > 0 && $urandom_range(0, 3) == 0) plan_len[p] = $urandom_range(6, 10);
                for (int w = 0; w < 16; w++) begin
                    if ($urandom_range(0, 15) == 0) plan_gap[p][w] = $urandom_range(0, TIMEOUT_CYC - 1);
                    else plan_gap[p][w] = $urandom_range(0, 2);
                    if (r > 0 && $urandom_range(0, 15) == 0) begin
                        plan_xor[p][w] = 64'd1 << $urandom_range(0, 63);
                    end
                end
            end
            if (r == 0) plan_gap[2][3] = TIMEOUT_CYC - 1;
            sp = (r == 0) ? 1 : int'($urandom_range(1, NUM_PKTS - 1));
            plan_gap[0][0]  = 0;
            plan_gap[sp][0] = 0;
            do_start($sformatf("rand%0d", r));
            drive_plan($sformatf("rand%0d", r), sp, exp_err);
            finish_checks($sformatf("rand%0d", r), exp_err, exp_err == 0);
        end

        summary_and_finish();
    end

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: simulation still running, required finish");
        $fatal(1);
    end

endmodule
